// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
//
// Sequencer for a small load/store processor. It holds the program counter,
// the instruction register and a Moore FSM. The FSM decodes the instruction
// register and drives the data memory and register file control signals.
//
// Ports
//   Clk         in   1   system clock, all state updates on the rising edge
//   Reset       in   1   synchronous, active-low reset
//   IM_Q        in  16   instruction word read from address PC_Out
//   PC_Out      out  7   program counter / instruction memory address
//   IR_Out      out 16   instruction register
//   OutState    out  4   current FSM state code
//   NextState   out  4   state entered on the next rising edge
//   D_Addr      out  8   data memory address
//   D_wr        out  1   data memory write enable
//   RF_Ra_Addr  out  4   register file read port A address
//   RF_Rb_Addr  out  4   register file read port B address
//   RF_W_Addr   out  4   register file write address
//   RF_W_en     out  1   register file write enable
//   RF_s        out  1   write-back select: 1 = data memory, 0 = ALU
//   ALU_s0      out  3   ALU function select
// ----------------------------------------------------------------------------
module control_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IM_Q,
    output logic [6:0]  PC_Out,
    output logic [15:0] IR_Out,
    output logic [3:0]  OutState,
    output logic [3:0]  NextState,
    output logic [7:0]  D_Addr,
    output logic        D_wr,
    output logic [3:0]  RF_Ra_Addr,
    output logic [3:0]  RF_Rb_Addr,
    output logic [3:0]  RF_W_Addr,
    output logic        RF_W_en,
    output logic        RF_s,
    output logic [2:0]  ALU_s0
);

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        NOOP   = 4'd3,
        LOADA  = 4'd4,
        LOADB  = 4'd5,
        STORE  = 4'd6,
        ADD    = 4'd7,
        SUB    = 4'd8,
        HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic [7:0] d_addr;
        logic       d_wr;
        logic [3:0] ra_addr;
        logic [3:0] rb_addr;
        logic [3:0] w_addr;
        logic       w_en;
        logic       rf_s;
        logic [2:0] alu_s0;
    } ctrl_t;

    state_t      state;
    state_t      next_state;
    logic [6:0]  pc;
    logic [15:0] ir;
    ctrl_t       ctrl;

    // Control word for a given state and instruction. Anything not named for
    // a state stays zero.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [15:0] ins);
        ctrl_t c;
        c = '0;
        case (s)
            LOADA, LOADB: begin
                c.d_addr = ins[11:4];
                c.w_addr = ins[3:0];
                c.rf_s   = 1'b1;
                c.w_en   = (s == LOADB);
            end
            STORE: begin
                c.d_addr  = ins[11:4];
                c.ra_addr = ins[3:0];
                c.d_wr    = 1'b1;
            end
            ADD, SUB: begin
                c.ra_addr = ins[11:8];
                c.rb_addr = ins[7:4];
                c.w_addr  = ins[3:0];
                c.w_en    = 1'b1;
                c.alu_s0  = (s == ADD) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
        return c;
    endfunction

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        if (!Reset) begin
            next_state = INIT;
        end else begin
            case (state)
                INIT:   next_state = FETCH;
                FETCH:  next_state = DECODE;
                DECODE: begin
                    case (ir[15:12])
                        4'b0000: next_state = NOOP;
                        4'b0001: next_state = STORE;
                        4'b0010: next_state = LOADA;
                        4'b0011: next_state = ADD;
                        4'b0100: next_state = SUB;
                        4'b0101: next_state = HALT;
                        default: next_state = NOOP;
                    endcase
                end
                LOADA:  next_state = LOADB;
                HALT:   next_state = HALT;
                default: next_state = FETCH;  // NoOp, LoadB, Store, Add, Sub
            endcase
        end
    end

    // The control word is registered from next_state so it always equals
    // decode_ctrl(OutState, IR_Out) without a combinational path. IR is only
    // loaded on the Fetch edge, which enters Decode (an all-zero state), so
    // the IR value used here is already the one the execute states see.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= INIT;
            pc    <= '0;
            ir    <= '0;
            ctrl  <= '0;
        end else begin
            state <= next_state;
            ctrl  <= decode_ctrl(next_state, ir);
            // Init clears the PC; Fetch captures the word at the current
            // address and advances. Every other state, Halt included, holds.
            if (state == INIT) begin
                pc <= '0;
            end else if (state == FETCH) begin
                pc <= pc + 7'd1;
            end
            if (state == FETCH) begin
                ir <= IM_Q;
            end
        end
    end

    assign PC_Out     = pc;
    assign IR_Out     = ir;
    assign OutState   = state;
    assign NextState  = next_state;
    assign D_Addr     = ctrl.d_addr;
    assign D_wr       = ctrl.d_wr;
    assign RF_Ra_Addr = ctrl.ra_addr;
    assign RF_Rb_Addr = ctrl.rb_addr;
    assign RF_W_Addr  = ctrl.w_addr;
    assign RF_W_en    = ctrl.w_en;
    assign RF_s       = ctrl.rf_s;
    assign ALU_s0     = ctrl.alu_s0;

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
//
// Directed bench for control_unit. An asynchronous-read instruction memory is
// modelled as an array indexed by PC_Out. Outputs are sampled 1 time unit
// after each rising edge.
// ----------------------------------------------------------------------------
module tb_control_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IM_Q;
    logic [6:0]  PC_Out;
    logic [15:0] IR_Out;
    logic [3:0]  OutState;
    logic [3:0]  NextState;
    logic [7:0]  D_Addr;
    logic        D_wr;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [3:0]  RF_W_Addr;
    logic        RF_W_en;
    logic        RF_s;
    logic [2:0]  ALU_s0;

    logic [15:0] mem [128];
    int checks = 0;
    int errors = 0;

    assign IM_Q = mem[PC_Out];

    always #5 Clk = ~Clk;

    control_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IM_Q       (IM_Q),
        .PC_Out     (PC_Out),
        .IR_Out     (IR_Out),
        .OutState   (OutState),
        .NextState  (NextState),
        .D_Addr     (D_Addr),
        .D_wr       (D_wr),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_s       (RF_s),
        .ALU_s0     (ALU_s0)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Enables and ALU select must all be zero outside execute states.
    task automatic check_idle(input string tag);
        check({tag, " D_wr"}, {15'd0, D_wr}, 16'd0);
        check({tag, " RF_W_en"}, {15'd0, RF_W_en}, 16'd0);
        check({tag, " ALU_s0"}, {13'd0, ALU_s0}, 16'd0);
    endtask

    task automatic fill_mem(input logic [15:0] w);
        for (int i = 0; i < 128; i++) mem[i] = w;
    endtask

    // Two reset edges, then release; on return the DUT sits in Init.
    task automatic do_reset();
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
    endtask

    initial begin
        // ---------------- reset and a single NoOp ----------------
        fill_mem(16'h0000);
        Reset = 1'b0;
        #1;
        check("next_state_in_reset", {12'd0, NextState}, 16'd0);
        step();
        step();
        check("rst_state", {12'd0, OutState}, 16'd0);
        check("rst_pc", {9'd0, PC_Out}, 16'd0);
        check("rst_ir", IR_Out, 16'h0000);
        check_idle("rst");
        Reset = 1'b1;
        #1;
        check("init_next", {12'd0, NextState}, 16'd1);
        step();
        check("noop_fetch", {12'd0, OutState}, 16'd1);
        check("noop_fetch_pc", {9'd0, PC_Out}, 16'd0);
        step();
        check("noop_decode", {12'd0, OutState}, 16'd2);
        check("noop_decode_pc", {9'd0, PC_Out}, 16'd1);
        step();
        check("noop_exec", {12'd0, OutState}, 16'd3);
        check_idle("noop_exec");
        step();
        check("noop_refetch", {12'd0, OutState}, 16'd1);

        // ---------------- load ----------------
        fill_mem(16'h0000);
        mem[0] = 16'h2A53;
        do_reset();
        check("ld_init", {12'd0, OutState}, 16'd0);
        step();
        step();
        check("ld_ir", IR_Out, 16'h2A53);
        check("ld_next", {12'd0, NextState}, 16'd4);
        step();
        check("lda_state", {12'd0, OutState}, 16'd4);
        check("lda_daddr", {8'd0, D_Addr}, 16'h00A5);
        check("lda_waddr", {12'd0, RF_W_Addr}, 16'd3);
        check("lda_rfs", {15'd0, RF_s}, 16'd1);
        check("lda_wen", {15'd0, RF_W_en}, 16'd0);
        check("lda_dwr", {15'd0, D_wr}, 16'd0);
        step();
        check("ldb_state", {12'd0, OutState}, 16'd5);
        check("ldb_daddr", {8'd0, D_Addr}, 16'h00A5);
        check("ldb_waddr", {12'd0, RF_W_Addr}, 16'd3);
        check("ldb_rfs", {15'd0, RF_s}, 16'd1);
        check("ldb_wen", {15'd0, RF_W_en}, 16'd1);
        step();
        check("ld_back_fetch", {12'd0, OutState}, 16'd1);
        check("ld_back_rfs", {15'd0, RF_s}, 16'd0);
        check_idle("ld_back");

        // ---------------- store ----------------
        fill_mem(16'h0000);
        mem[0] = 16'h1B72;
        do_reset();
        step();
        step();
        step();
        check("st_state", {12'd0, OutState}, 16'd6);
        check("st_daddr", {8'd0, D_Addr}, 16'h00B7);
        check("st_ra", {12'd0, RF_Ra_Addr}, 16'd2);
        check("st_dwr", {15'd0, D_wr}, 16'd1);
        check("st_wen", {15'd0, RF_W_en}, 16'd0);
        step();
        check("st_after_state", {12'd0, OutState}, 16'd1);
        check("st_after_dwr", {15'd0, D_wr}, 16'd0);

        // ---------------- add, sub, halt ----------------
        fill_mem(16'h0000);
        mem[0] = 16'h3123;
        mem[1] = 16'h4456;
        mem[2] = 16'h5000;
        do_reset();
        step();
        step();
        step();
        check("add_state", {12'd0, OutState}, 16'd7);
        check("add_ra", {12'd0, RF_Ra_Addr}, 16'd1);
        check("add_rb", {12'd0, RF_Rb_Addr}, 16'd2);
        check("add_w", {12'd0, RF_W_Addr}, 16'd3);
        check("add_alu", {13'd0, ALU_s0}, 16'd1);
        check("add_rfs", {15'd0, RF_s}, 16'd0);
        check("add_wen", {15'd0, RF_W_en}, 16'd1);
        check("add_dwr", {15'd0, D_wr}, 16'd0);
        step();
        check("sub_fetch", {12'd0, OutState}, 16'd1);
        check("sub_fetch_pc", {9'd0, PC_Out}, 16'd1);
        step();
        check("sub_decode", {12'd0, OutState}, 16'd2);
        step();
        check("sub_state", {12'd0, OutState}, 16'd8);
        check("sub_ra", {12'd0, RF_Ra_Addr}, 16'd4);
        check("sub_rb", {12'd0, RF_Rb_Addr}, 16'd5);
        check("sub_w", {12'd0, RF_W_Addr}, 16'd6);
        check("sub_alu", {13'd0, ALU_s0}, 16'd2);
        check("sub_wen", {15'd0, RF_W_en}, 16'd1);
        step();
        step();
        step();
        check("halt_state", {12'd0, OutState}, 16'd9);
        check("halt_pc", {9'd0, PC_Out}, 16'd3);
        for (int i = 0; i < 22; i++) begin
            step();
            check("halt_hold_state", {12'd0, OutState}, 16'd9);
            check("halt_hold_pc", {9'd0, PC_Out}, 16'd3);
            check("halt_hold_ir", IR_Out, 16'h5000);
            check_idle("halt_hold");
        end
        Reset = 1'b0;
        #1;
        check("halt_rst_next", {12'd0, NextState}, 16'd0);
        step();
        check("halt_rst_state", {12'd0, OutState}, 16'd0);
        check("halt_rst_pc", {9'd0, PC_Out}, 16'd0);
        check("halt_rst_ir", IR_Out, 16'h0000);
        Reset = 1'b1;

        // ---------------- reset aborts store ----------------
        fill_mem(16'h0000);
        mem[0] = 16'h1B72;
        do_reset();
        step();
        step();
        step();
        check("abort_st_pre", {15'd0, D_wr}, 16'd1);
        Reset = 1'b0;
        step();
        check("abort_st_state", {12'd0, OutState}, 16'd0);
        check("abort_st_dwr", {15'd0, D_wr}, 16'd0);
        step();
        check("abort_st_dwr2", {15'd0, D_wr}, 16'd0);

        // ---------------- reset aborts load ----------------
        fill_mem(16'h0000);
        mem[0] = 16'h2A53;
        do_reset();
        step();
        step();
        step();
        check("abort_ld_pre", {12'd0, OutState}, 16'd4);
        Reset = 1'b0;
        step();
        check("abort_ld_state", {12'd0, OutState}, 16'd0);
        check("abort_ld_wen", {15'd0, RF_W_en}, 16'd0);
        Reset = 1'b1;
        step();
        check("abort_ld_wen2", {15'd0, RF_W_en}, 16'd0);
        check("abort_ld_fetch", {12'd0, OutState}, 16'd1);

        // ---------------- 128 NoOps with PC wrap, unknown opcode ----------------
        fill_mem(16'h0000);
        mem[5] = 16'hF000;
        mem[127] = 16'hF000;
        do_reset();
        for (int k = 0; k < 128; k++) begin
            step();
            check("wrap_fetch", {12'd0, OutState}, 16'd1);
            check("wrap_fetch_pc", {9'd0, PC_Out}, 16'(k));
            step();
            check("wrap_decode_pc", {9'd0, PC_Out}, 16'((k + 1) % 128));
            step();
            check("wrap_noop", {12'd0, OutState}, 16'd3);
        end
        check("wrap_pc_zero", {9'd0, PC_Out}, 16'd0);
        check("wrap_last_ir", IR_Out, 16'hF000);
        check_idle("wrap_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; ports:
- Clk  in  1  single system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- IM_Q  in  16  instruction word from external instruction memory at address PC_Out
- PC_Out  out  7  program counter, instruction memory address
- IR_Out  out  16  instruction register
- OutState  out  4  current FSM state code
- NextState  out  4  combinational next-state code
- D_Addr  out  8  data memory address
- D_wr  out  1  data memory write enable
- RF_Ra_Addr  out  4  register file read port A address
- RF_Rb_Addr  out  4  register file read port B address
- RF_W_Addr  out  4  register file write address
- RF_W_en  out  1  register file write enable
- RF_s  out  1  write-back mux select: 1 = data memory, 0 = ALU
- ALU_s0  out  3  ALU function select

Function
REQ-002 The block SHALL contain three sub-blocks: a program counter (PC), an instruction register (IR) and a Moore FSM.
REQ-003 PC SHALL have clear and increment controls; clear has priority; it wraps from 127 to 0; otherwise it holds.
REQ-004 IR SHALL load IM_Q on a rising edge when IR_ld=1, and otherwise hold.
REQ-005 FSM state codes SHALL be: Init=0, Fetch=1, Decode=2, NoOp=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9.
REQ-006 Transitions SHALL be:
- Init->Fetch
- Fetch->Decode
- Decode->by opcode IR_Out[15:12]
- NoOp, LoadB, Store, Add, Sub->Fetch
- LoadA->LoadB
- Halt->Halt
REQ-007 Decode dispatch SHALL be: 0000 NoOp, 0001 Store, 0010 LoadA, 0011 Add, 0100 Sub, 0101 Halt; any other opcode goes to NoOp.
REQ-008 Init SHALL assert PC clear.
REQ-009 Fetch SHALL assert IR_ld and PC increment together, so IR captures the word at the pre-increment address.
REQ-010 IM_Q SHALL be sampled at the end of Fetch; PC_Out is stable for at least one full cycle before every Fetch, so a synchronous-read ROM addressed by PC_Out is supported.
REQ-011 LoadA SHALL drive D_Addr=IR[11:4], RF_W_Addr=IR[3:0], RF_s=1, RF_W_en=0.
REQ-012 LoadB SHALL drive the same outputs as LoadA but with RF_W_en=1.
REQ-013 Store SHALL drive D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_wr=1.
REQ-014 Add SHALL drive RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], ALU_s0=3'b001, RF_s=0, RF_W_en=1.
REQ-015 Sub SHALL drive the same outputs as Add but with ALU_s0=3'b010.
REQ-016 In every state, any output not listed for that state SHALL be 0, including ALU_s0=3'b000, D_wr=0 and RF_W_en=0.
REQ-017 All control outputs SHALL be decoded from OutState and IR_Out only; they are glitch-free Moore outputs with no dependence on IM_Q.
REQ-018 NextState SHALL equal the state that will be entered on the next edge, including Init while Reset=0.
REQ-019 Halt SHALL freeze PC and IR, keep all enables 0, and be left only through reset.

Reset
REQ-020 While Reset=0 at a rising edge: OutState becomes Init, PC_Out becomes 0, and IR_Out becomes 16'h0000.
REQ-021 The following cycle SHALL be Init with PC clear asserted.
REQ-022 Reset asserted mid-instruction (for example in LoadA or Store) SHALL abort it; no D_wr or RF_W_en pulse occurs after the reset edge.
REQ-023 The first Fetch after reset release SHALL load the word at address 0.

Verification
REQ-024 Reset low 2 cycles, then high, IM_Q at address 0 = 16'h0000 -> OutState sequence 0,1,2,3,1; PC_Out 0 then 1 after Fetch; all enables 0.
REQ-025 Address 0 = 16'h2A53 (load) -> LoadA: D_Addr=8'hA5, RF_W_Addr=3, RF_s=1, RF_W_en=0; LoadB: same with RF_W_en=1; return to Fetch.
REQ-026 16'h1B72 (store) -> Store: D_Addr=8'hB7, RF_Ra_Addr=2, D_wr=1 for exactly one cycle.
REQ-027 16'h3123 (add) then 16'h4456 (sub) ->
- Add: Ra=1, Rb=2, W=3, ALU_s0=001, RF_W_en=1.
- Sub: Ra=4, Rb=5, W=6, ALU_s0=010.
- Each instruction occupies Fetch+Decode+execute = 3 cycles.
REQ-028 16'h5000 (halt) -> OutState stays 9 and PC_Out frozen for 20+ cycles; Reset low 1 cycle -> OutState=0, PC_Out=0.
REQ-029 128 consecutive NoOps -> PC_Out wraps 127->0; opcode 16'hF000 -> NoOp path (state 3).
